fifo_read_streamer: RTL
=======================

FIFO_READ_STREAMER -- requirements
Module: fifo_read_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, width of transfer_count.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1, discards buffered entries.
REQ-006 SHALL have port fifo_empty, input, 1, empty flag from the FIFO controller.
REQ-007 SHALL have port fifo_read_enable, output, 1, pops the FIFO head this cycle.
REQ-008 SHALL have port fifo_read_data, input, WIDTH, FIFO head data, valid in the same cycle as fifo_read_enable.
REQ-009 SHALL have port stream_valid, output, 1, output stream valid.
REQ-010 SHALL have port stream_ready, input, 1, output stream ready.
REQ-011 SHALL have port stream_data, output, WIDTH, output stream data.
REQ-012 SHALL have port buffer_level, output, 2, number of buffered entries (0..2).
REQ-013 SHALL have port transfer_count, output, COUNT_WIDTH, number of completed stream transfers.

Function
REQ-014 SHALL hold a 2-entry skid buffer (head, spare) with states EMPTY, ONE, TWO; buffer_level SHALL be 0/1/2 respectively.
REQ-015 Definitions: push = fifo_read_enable; pop = stream_valid && stream_ready.
REQ-016 SHALL set fifo_read_enable = !fifo_empty && !flush && state != TWO.
REQ-017 fifo_read_enable SHALL have no combinational dependency on stream_ready.
REQ-018 SHALL set stream_valid = (state != EMPTY) && !flush.
REQ-019 stream_data SHALL always equal the head register.
REQ-020 Transitions from EMPTY: push -> ONE, and head <= fifo_read_data.
REQ-021 Transitions from ONE:
- push && !pop -> TWO, spare <= data.
- pop && !push -> EMPTY.
- push && pop -> ONE, head <= data.
- neither -> hold.
REQ-022 Transitions from TWO: pop -> ONE, head <= spare; otherwise hold. No push occurs in TWO.
REQ-023 With fifo_empty low and stream_ready high continuously, SHALL sustain one transfer per cycle after a 1-cycle fill latency. The first data SHALL appear on stream_valid the cycle after the first push.
REQ-024 While stream_valid && !stream_ready, stream_data and stream_valid SHALL remain stable.
REQ-025 flush SHALL take priority over push and pop: next state EMPTY, no FIFO pop, no transfer counted that cycle.
REQ-026 transfer_count SHALL increment by 1 on each pop and SHALL wrap from 2^COUNT_WIDTH-1 to 0. Flush SHALL NOT clear it.
REQ-027 Entries SHALL leave the stream in FIFO order, with no duplication or loss except on flush.

Reset
REQ-028 On reset high at a clock edge, the block SHALL enter state EMPTY and clear transfer_count.
REQ-029 While reset is high: fifo_read_enable=0, stream_valid=0, buffer_level=0. stream_data is don't-care (head register may be left unreset).
REQ-030 Reset SHALL override flush, push and pop. Reset mid-burst SHALL discard both buffered entries.

Structure
REQ-031 State encoding SHALL be local constants. No shared package is required: the block introduces no cross-module typedefs.
REQ-032 transfer_count SHALL be built from the existing advanced_wrapping_counter (RANGE 2^COUNT_WIDTH, increment = pop, decrement/load tied 0); no other sub-module.
REQ-033 The block SHALL connect directly to the FIFO controller read port (empty, read_enable, read_data) with no glue logic.

Verification
REQ-034 Streaming: FIFO preloaded with 0x10..0x17, stream_ready=1 -> stream_data 0x10..0x17 on 8 consecutive valid cycles starting 1 cycle after first push; transfer_count=8.
REQ-035 Backpressure: 0xA1,0xA2,0xA3 queued, stream_ready=0 for 5 cycles:
- buffer_level reaches 2.
- fifo_read_enable stays 0 in TWO.
- stream_data holds 0xA1.
- after ready=1, 0xA1,0xA2,0xA3 appear in order.
REQ-036 Flush in TWO: flush pulsed one cycle -> next cycle buffer_level=0, stream_valid=0, no transfer counted; subsequent FIFO data resumes in order.
REQ-037 Counter wrap: COUNT_WIDTH=4, 17 transfers -> transfer_count=1.
REQ-038 Reset mid-operation: reset asserted in TWO -> next cycle state EMPTY, transfer_count=0, fifo_read_enable=0 while reset high.
REQ-039 Random: random fifo_empty and stream_ready over 10000 cycles against a scoreboard -> in-order, lossless, and REQ-024 never violated.

Source files
------------

// File: rtl/advanced_wrapping_counter.sv
// advanced_wrapping_counter: modulo-RANGE up/down counter with synchronous load.
module advanced_wrapping_counter #(
    parameter int RANGE = 16,
    parameter int WIDTH = (RANGE > 1) ? $clog2(RANGE) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_increment,
    input  logic             i_decrement,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_count
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(RANGE - 1);
    always_ff @(posedge clock) begin
        if (reset) o_count <= '0;
        else if (i_load) o_count <= i_load_value;
        else if (i_increment && !i_decrement) o_count <= (o_count == MAX) ? '0 : o_count + 1'b1;
        else if (i_decrement && !i_increment) o_count <= (o_count == '0) ? MAX : o_count - 1'b1;
    end
endmodule

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: turns a FIFO read port into a valid/ready stream through a 2-entry skid buffer.
module fifo_read_streamer #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    input  logic [WIDTH-1:0]       fifo_read_data,
    output logic                   stream_valid,
    input  logic                   stream_ready,
    output logic [WIDTH-1:0]       stream_data,
    output logic [1:0]             buffer_level,
    output logic [COUNT_WIDTH-1:0] transfer_count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_spare;
    logic             w_push;
    logic             w_pop;
    // Reading only while a slot is free keeps the FIFO pop independent of stream_ready.
    assign w_push           = !reset && !flush && !fifo_empty && r_state != TWO;
    assign w_pop            = stream_valid && stream_ready;
    assign fifo_read_enable = w_push;
    assign stream_valid     = !reset && !flush && r_state != EMPTY;
    assign stream_data      = r_head;
    assign buffer_level     = reset ? 2'd0 : r_state;
    always_ff @(posedge clock) begin
        if (reset || flush) r_state <= EMPTY;
        else case (r_state)
            EMPTY: if (w_push) begin
                r_state <= ONE;
                r_head  <= fifo_read_data;
            end
            ONE: begin
                if (w_push && !w_pop) begin
                    r_state <= TWO;
                    r_spare <= fifo_read_data;
                end else if (w_pop && !w_push) r_state <= EMPTY;
                else if (w_push) r_head <= fifo_read_data;
            end
            TWO: if (w_pop) begin
                r_state <= ONE;
                r_head  <= r_spare;
            end
            default: r_state <= EMPTY;
        endcase
    end
    advanced_wrapping_counter #(
        .RANGE(2 ** COUNT_WIDTH),
        .WIDTH(COUNT_WIDTH)
    ) u_count (
        .clock       (clock),
        .reset       (reset),
        .i_increment (w_pop),
        .i_decrement (1'b0),
        .i_load      (1'b0),
        .i_load_value({COUNT_WIDTH{1'b0}}),
        .o_count     (transfer_count)
    );
endmodule
